pipe_accum_chain: RTL

- Parametrised multi-channel successor to the single free-running counter stage (q_c <= q_c + 1).
- Keeps one accumulator per channel and adds each accepted input sample to the selected channel's accumulator.
- Sends the updated (channel, sum) result through a DEPTH-stage elastic valid/ready pipeline with backpressure.
- Sits between a sample producer and any downstream consumer in the datapath.

---
 rtl/pipe_accum_pkg.sv | 19 +
 rtl/pipe_accum_chain_stage.sv | 33 +++
 rtl/pipe_accum_chain.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_accum_pkg.sv
// Shared definitions for the multi-channel accumulator chain: width helpers
// and the adder mode encodings.
package pipe_accum_pkg;

    // Adder behaviour selected by the SAT_MODE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Channel index width; a single channel still needs one select bit
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    // Width of an occupancy counter that must reach DEPTH inclusive
    function automatic int level_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_accum_chain_stage.sv
// One elastic valid/ready register stage. A stage loads whenever it is empty
// or its content leaves this cycle, so bubbles collapse and a full chain still
// moves one item per cycle. Data is only written on a real load so that a
// stalled output holds its value.
module pipe_elastic_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             resetn,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    assign up_ready = !dn_valid || dn_ready;

    // Register the stage content whenever the slot is free or being vacated
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_accum_chain.sv
// Multi-channel accumulator feeding a DEPTH-stage elastic output pipeline.
// Each accepted sample updates its channel's accumulator in one cycle and the
// post-update (channel, sum) pair travels down the pipeline.
// Optional build macro PIPE_ACCUM_OVF_FLAG_EN adds o_ovf, one sticky overflow
// flag per channel.
module pipe_accum_chain
    import pipe_accum_pkg::*;
#(
    parameter  int W_DATA   = 32,
    parameter  int N_CH     = 4,
    parameter  int DEPTH    = 3,
    parameter  int SAT_MODE = MODE_WRAP,
    localparam int CH_W     = ch_width(N_CH),
    localparam int LVL_W    = level_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              resetn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CH_W-1:0]   i_ch,
    input  logic [W_DATA-1:0] i_data,
    input  logic              i_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CH_W-1:0]   o_ch,
    output logic [W_DATA-1:0] o_sum,
    output logic [LVL_W-1:0]  o_level
`ifdef PIPE_ACCUM_OVF_FLAG_EN
    ,
    output logic [N_CH-1:0]   o_ovf
`endif
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [W_DATA-1:0] sum;
    } result_t;

    localparam int RES_W = $bits(result_t);

    // Wrap or clamp the sum depending on the adder mode
    function automatic logic [W_DATA-1:0] sat_add_f(input logic [W_DATA-1:0] a,
                                                    input logic [W_DATA-1:0] b);
        logic [W_DATA:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT_MODE == MODE_SAT && s[W_DATA]) begin
            return '1;
        end
        return s[W_DATA-1:0];
    endfunction

`ifdef PIPE_ACCUM_OVF_FLAG_EN
    // Carry out of the add; a clamp happens exactly when this is set
    function automatic logic carry_f(input logic [W_DATA-1:0] a,
                                     input logic [W_DATA-1:0] b);
        logic [W_DATA:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W_DATA];
    endfunction
`endif

    logic [W_DATA-1:0] acc [N_CH];
    logic [W_DATA-1:0] acc_sel;
    logic [W_DATA-1:0] acc_base;
    logic [W_DATA-1:0] new_sum;
    logic              run_en;
    logic              accept;
    logic              ch_ok;
    logic              load_p0;
    logic              exit_out;

    logic [DEPTH:0]    vld_p;
    logic [DEPTH:0]    rdy_p;
    result_t           data_p [DEPTH+1];

    // o_ready stays low during reset and for the first edge after release
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    assign o_ready  = run_en && rdy_p[0];
    assign accept   = i_valid && o_ready;
    assign ch_ok    = ({1'b0, i_ch} < (CH_W+1)'(N_CH));
    assign load_p0  = accept && ch_ok;
    assign exit_out = o_valid && i_ready;

    // Select the addressed accumulator without indexing past the array
    always_comb begin
        acc_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_ch == CH_W'(c)) begin
                acc_sel = acc[c];
            end
        end
    end

    // A clear in the same cycle as a sample makes the sample start from zero
    assign acc_base = i_clr ? '0 : acc_sel;
    assign new_sum  = sat_add_f(acc_base, i_data);

    // Accumulator update: the sampled channel takes the new sum, clear zeroes the rest
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < N_CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (load_p0 && i_ch == CH_W'(c)) begin
                    acc[c] <= new_sum;
                end else if (i_clr) begin
                    acc[c] <= '0;
                end
            end
        end
    end

    // ---- stage 0 input: post-update result enters on the accept edge ----
    assign vld_p[0]     = load_p0;
    assign data_p[0]    = '{ch: i_ch, sum: new_sum};
    assign rdy_p[DEPTH] = i_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_elastic_stage #(
            .WIDTH(RES_W)
        ) u_stage (
            .i_clk    (i_clk),
            .resetn   (resetn),
            .up_valid (vld_p[k]),
            .up_data  (data_p[k]),
            .up_ready (rdy_p[k]),
            .dn_valid (vld_p[k+1]),
            .dn_data  (data_p[k+1]),
            .dn_ready (rdy_p[k+1])
        );
    end

    // ---- output: last stage drives the result ports ----
    assign o_valid = vld_p[DEPTH];
    assign o_ch    = data_p[DEPTH].ch;
    assign o_sum   = data_p[DEPTH].sum;

    // Occupancy: one up per result entering, one down per result leaving
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            o_level <= '0;
        end else begin
            case ({load_p0, exit_out})
                2'b10:   o_level <= o_level + LVL_W'(1);
                2'b01:   o_level <= o_level - LVL_W'(1);
                default: o_level <= o_level;
            endcase
        end
    end

`ifdef PIPE_ACCUM_OVF_FLAG_EN
    // Sticky per-channel overflow; clear has priority over a coinciding overflow
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            o_ovf <= '0;
        end else if (i_clr) begin
            o_ovf <= '0;
        end else if (load_p0 && carry_f(acc_sel, i_data)) begin
            for (int c = 0; c < N_CH; c++) begin
                if (i_ch == CH_W'(c)) begin
                    o_ovf[c] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
